// File: rtl/ado_spike_ctrl_if.sv
// Sample stream and spike-event handshake for ado_spike_ctrl.
// master: sample producer / event consumer side; slave: the controller.
interface ado_spike_ctrl_if;
    logic signed [15:0] sample_in;
    logic               sample_valid;
    logic               spike_valid;
    logic               spike_ready;

    modport master (
        output sample_in,
        output sample_valid,
        output spike_ready,
        input  spike_valid
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        input  spike_ready,
        output spike_valid
    );
endinterface

// File: rtl/ado_spike_ctrl.sv
// ado_spike_ctrl: amplitude-difference-operator spike detector.
// ado = |x[n] - x[n-3]|, saturated to 32767. A training phase averages
// 2^TRAIN_LOG2 qualified ado values and scales the mean by 2^THR_SHIFT to
// form the threshold; operation then flags every qualified sample whose ado
// strictly exceeds the threshold as a valid/ready spike event.
// Optional feature: define ADO_REFRACTORY_EN to make each detection enter a
// refractory period of REFRACT_LEN valid samples during which nothing detects.
module ado_spike_ctrl #(
    parameter int unsigned TRAIN_LOG2  = 8,
    parameter int unsigned THR_SHIFT   = 3,
    parameter int unsigned REFRACT_LEN = 16
) (
    input  logic               clk,
    input  logic               rst,
    ado_spike_ctrl_if.slave    bus,
    input  logic               start,
    input  logic               override_en,
    input  logic signed [15:0] thr_override,
    output logic signed [15:0] threshold_out,
    output logic               spike_drop,
    output logic [1:0]         state_out,
    output logic [15:0]        event_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAIN   = 2'd1,
        OPERATE = 2'd2,
        REFRACT = 2'd3
    } state_t;

    localparam int unsigned ACC_W = 16 + TRAIN_LOG2;
    localparam int unsigned CNT_W = TRAIN_LOG2 + 1;
    localparam int unsigned RC_W  = $clog2(REFRACT_LEN + 1);
    localparam int unsigned SC_W  = 16 + THR_SHIFT;

    localparam logic signed [15:0] THR_DEFAULT  = 16'sd500;
    localparam logic signed [15:0] ADO_MAX      = 16'sd32767;
    localparam logic [CNT_W-1:0]   TRAIN_LAST   = CNT_W'((1 << TRAIN_LOG2) - 1);
    localparam logic [RC_W-1:0]    REFRACT_LAST = RC_W'(REFRACT_LEN - 1);

`ifdef ADO_REFRACTORY_EN
    localparam logic REFRACT_ON = 1'b1;
`else
    localparam logic REFRACT_ON = 1'b0;
`endif

    state_t             state, state_nxt;
    logic signed [15:0] dly [3];
    logic [1:0]         prime_cnt;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   train_cnt;
    logic [RC_W-1:0]    refract_cnt;
    logic signed [15:0] thr_trained;
    logic               spike_valid_q;

    logic [16:0]        diff, mag;
    logic signed [15:0] ado;
    logic [ACC_W-1:0]   acc_sum;
    logic [15:0]        mean;
    logic [SC_W-1:0]    scaled;
    logic signed [15:0] trained;
    logic               qualified, accept, detect, train_last;

    // The incoming sample is the newest tap; the three stored taps complete
    // the 4-deep line, so dly[2] is x[n-3].
    assign qualified = bus.sample_valid && (prime_cnt == 2'd3);
    assign accept    = spike_valid_q && bus.spike_ready;

    assign bus.spike_valid = spike_valid_q;
    assign state_out       = state;

    // ado magnitude on 17 bits, trained threshold from the running sum
    always_comb begin
        diff    = {bus.sample_in[15], bus.sample_in} - {dly[2][15], dly[2]};
        mag     = diff[16] ? (~diff + 17'd1) : diff;
        ado     = (mag > 17'd32767) ? ADO_MAX : $signed(mag[15:0]);
        acc_sum = acc + ACC_W'($unsigned(ado));
        mean    = acc_sum[TRAIN_LOG2 +: 16];
        scaled  = SC_W'(mean) << THR_SHIFT;
        trained = (scaled > SC_W'(32767)) ? ADO_MAX : $signed(scaled[15:0]);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state plus the detect / training-complete strobes; start overrides all
    always_comb begin
        state_nxt  = state;
        detect     = 1'b0;
        train_last = 1'b0;
        if (start) begin
            state_nxt = TRAIN;
        end else begin
            unique case (state)
                TRAIN: begin
                    if (qualified && train_cnt == TRAIN_LAST) begin
                        train_last = 1'b1;
                        state_nxt  = OPERATE;
                    end
                end
                OPERATE: begin
                    if (qualified && ado > threshold_out) begin
                        detect = 1'b1;
                        if (REFRACT_ON) state_nxt = REFRACT;
                    end
                end
                REFRACT: begin
                    if (bus.sample_valid && refract_cnt == REFRACT_LAST) state_nxt = OPERATE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    // Delay line, priming, training accumulator and refractory counter
    always_ff @(posedge clk) begin
        if (rst) begin
            dly         <= '{default: '0};
            prime_cnt   <= '0;
            acc         <= '0;
            train_cnt   <= '0;
            refract_cnt <= '0;
        end else begin
            if (bus.sample_valid) begin
                dly[2] <= dly[1];
                dly[1] <= dly[0];
                dly[0] <= bus.sample_in;
            end
            if (start)                                      prime_cnt <= '0;
            else if (bus.sample_valid && prime_cnt != 2'd3) prime_cnt <= prime_cnt + 2'd1;
            if (start) begin
                acc       <= '0;
                train_cnt <= '0;
            end else if (state == TRAIN && qualified) begin
                acc       <= acc_sum;
                train_cnt <= train_cnt + 1'b1;
            end
            if (state != REFRACT)       refract_cnt <= '0;
            else if (bus.sample_valid)  refract_cnt <= refract_cnt + 1'b1;
        end
    end

    // Threshold in force: default in IDLE, held in TRAIN, override-or-trained after
    always_ff @(posedge clk) begin
        if (rst) begin
            thr_trained   <= THR_DEFAULT;
            threshold_out <= THR_DEFAULT;
        end else if (train_last) begin
            thr_trained   <= trained;
            threshold_out <= trained;
        end else begin
            unique case (state)
                IDLE:             threshold_out <= THR_DEFAULT;
                OPERATE, REFRACT: threshold_out <= override_en ? thr_override : thr_trained;
                default:          threshold_out <= threshold_out;
            endcase
        end
    end

    // Event handshake: a new detection re-arms spike_valid even when the
    // pending event is accepted in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            spike_valid_q <= 1'b0;
            spike_drop    <= 1'b0;
            event_count   <= '0;
        end else begin
            if (detect)      spike_valid_q <= 1'b1;
            else if (accept) spike_valid_q <= 1'b0;
            if (accept) event_count <= event_count + 16'd1;
            if (start)                                             spike_drop <= 1'b0;
            else if (detect && spike_valid_q && !bus.spike_ready)  spike_drop <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ado_spike_ctrl.sv
// Self-checking bench for ado_spike_ctrl: directed scenarios plus randomized
// phases, every cycle compared against a behavioural model kept here.
module tb_ado_spike_ctrl;

    localparam int TL      = 8;
    localparam int TS      = 3;
    localparam int RLEN    = 16;
    localparam int TRAIN_N = 1 << TL;
`ifdef ADO_REFRACTORY_EN
    localparam bit REFR = 1'b1;
`else
    localparam bit REFR = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               start;
    logic               override_en;
    logic signed [15:0] thr_override;
    logic signed [15:0] threshold_out;
    logic               spike_drop;
    logic [1:0]         state_out;
    logic [15:0]        event_count;

    ado_spike_ctrl_if bus ();

    ado_spike_ctrl #(
        .TRAIN_LOG2 (TL),
        .THR_SHIFT  (TS),
        .REFRACT_LEN(RLEN)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .start        (start),
        .override_en  (override_en),
        .thr_override (thr_override),
        .threshold_out(threshold_out),
        .spike_drop   (spike_drop),
        .state_out    (state_out),
        .event_count  (event_count)
    );

    always #5 clk = ~clk;

    int checks;
    int failures;

    // Behavioural model: 0=idle 1=train 2=operate 3=refractory
    int     m_state, m_thr, m_trained, m_count, m_nq, m_refr, primed;
    longint m_acc;
    bit     m_valid, m_drop;
    int     hist[$];

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int rnd16();
        logic [15:0] r;
        r = 16'($urandom);
        return int'($signed(r));
    endfunction

    task automatic model_reset();
        m_state = 0; m_thr = 500; m_trained = 500; m_count = 0;
        m_nq = 0; m_refr = 0; primed = 0; m_acc = 0;
        m_valid = 0; m_drop = 0;
        hist = '{0, 0, 0};
    endtask

    task automatic model_step(input bit v, input int s, input bit st);
        int ado, tr;
        bit qual, det, last, acc_ok;
        ado = 0;
        if (v) begin
            ado = s - hist[0];
            if (ado < 0) ado = -ado;
            if (ado > 32767) ado = 32767;
        end
        qual   = v && (primed >= 3);
        det    = (m_state == 2) && qual && !st && (ado > m_thr);
        last   = (m_state == 1) && qual && !st && (m_nq == TRAIN_N - 1);
        acc_ok = m_valid && spike_ready_now();
        if (last) begin
            tr = int'(((m_acc + ado) / TRAIN_N) * (1 << TS));
            if (tr > 32767) tr = 32767;
            m_trained = tr;
            m_thr = tr;
        end else if (m_state == 0) begin
            m_thr = 500;
        end else if (m_state >= 2) begin
            m_thr = override_en ? int'(thr_override) : m_trained;
        end
        if (st) m_drop = 0;
        else if (det && m_valid && !spike_ready_now()) m_drop = 1;
        if (acc_ok) m_count = (m_count + 1) % 65536;
        if (det) m_valid = 1;
        else if (acc_ok) m_valid = 0;
        if (st) begin
            m_acc = 0; m_nq = 0;
        end else if (m_state == 1 && qual) begin
            m_acc += ado; m_nq++;
        end
        if (st) m_state = 1;
        else if (last) m_state = 2;
        else if (det && REFR) begin
            m_state = 3; m_refr = 0;
        end else if (m_state == 3 && v) begin
            m_refr++;
            if (m_refr == RLEN) m_state = 2;
        end
        if (st) primed = 0;
        else if (v) primed++;
        if (v) begin
            hist.push_back(s);
            hist.delete(0);
        end
    endtask

    function automatic bit spike_ready_now();
        return bus.spike_ready;
    endfunction

    task automatic check_all();
        chk("state_out", state_out, m_state);
        chk("threshold_out", threshold_out, m_thr);
        chk("spike_valid", bus.spike_valid, m_valid);
        chk("spike_drop", spike_drop, m_drop);
        chk("event_count", event_count, m_count);
    endtask

    task automatic cyc(input bit v, input int s, input bit st);
        bus.sample_valid = v;
        bus.sample_in    = 16'(s);
        start            = st;
        model_step(v, s, st);
        @(posedge clk);
        #1;
        bus.sample_valid = 1'b0;
        start            = 1'b0;
        check_all();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.sample_valid = 1'b0;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int cnt0;
        checks = 0;
        failures = 0;
        rst = 1'b0; start = 1'b0; override_en = 1'b0; thr_override = '0;
        bus.sample_in = '0; bus.sample_valid = 1'b0; bus.spike_ready = 1'b0;

        // Reset values
        do_reset();
        chk("rst_state", state_out, 0);
        chk("rst_thr", threshold_out, 500);
        chk("rst_valid", bus.spike_valid, 0);
        chk("rst_drop", spike_drop, 0);
        chk("rst_count", event_count, 0);

        // No start: samples never leave IDLE
        for (int i = 0; i < 1000; i++) begin
            bus.spike_ready = 1'($urandom);
            cyc(1'b1, rnd16(), 1'b0);
        end
        chk("idle_state", state_out, 0);
        chk("idle_thr", threshold_out, 500);
        chk("idle_valid", bus.spike_valid, 0);

        // Training on alternating 0/100 gives threshold 100<<3
        bus.spike_ready = 1'b1;
        cyc(1'b0, 0, 1'b1);
        for (int i = 0; i < 259; i++) begin
            cyc(1'b1, (i % 2 == 1) ? 100 : 0, 1'b0);
            if (i == 257) begin
                chk("train_hold_state", state_out, 1);
                chk("train_hold_thr", threshold_out, 500);
            end
        end
        chk("trained_state", state_out, 2);
        chk("trained_thr", threshold_out, 800);

        // Strict comparison: 801 detects, 800 does not
        bus.spike_ready = 1'b0;
        cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0); cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 801, 1'b0);
        chk("det_801", bus.spike_valid, 1);
        bus.spike_ready = 1'b1;
        for (int i = 0; i < 6; i++) cyc(1'b1, 0, 1'b0);
        cyc(1'b1, 800, 1'b0);
        chk("nodet_800", bus.spike_valid, 0);

        // Detections while unaccepted: event held, drop sticky, count frozen
        bus.spike_ready = 1'b0;
        cnt0 = m_count;
        for (int i = 0; i < 24; i++) cyc(1'b1, (i % 4 == 3) ? 2000 : 0, 1'b0);
        chk("hold_valid", bus.spike_valid, 1);
        chk("hold_drop", spike_drop, 1);
        chk("hold_count", event_count, cnt0);
        bus.spike_ready = 1'b1;
        cyc(1'b0, 0, 1'b0);
        chk("accept_valid", bus.spike_valid, 0);
        chk("accept_count", event_count, (cnt0 + 1) % 65536);

`ifdef ADO_REFRACTORY_EN
        // Refractory window: 16 valid samples ignored, 17th detects
        for (int i = 0; i < 40 && m_state != 2; i++) cyc(1'b1, 0, 1'b0);
        for (int i = 0; i < 40 && m_state != 3; i++) cyc(1'b1, (i % 2 == 1) ? 20000 : 0, 1'b0);
        cyc(1'b0, 0, 1'b0);
        for (int k = 1; k <= RLEN; k++) begin
            cyc(1'b1, (k % 2 == 1) ? 20000 : 0, 1'b0);
            chk("refract_state", state_out, (k == RLEN) ? 2 : 3);
            chk("refract_quiet", bus.spike_valid, 0);
        end
        cyc(1'b1, 20000, 1'b0);
        chk("refract_17th", bus.spike_valid, 1);
`endif

        // Saturation: a full-scale step must not wrap
        for (int i = 0; i < 20; i++) cyc(1'b1, 0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b1, -32768, 1'b0);
`ifndef ADO_REFRACTORY_EN
        chk("sat_pre", bus.spike_valid, 0);
`endif
        cyc(1'b1, 32767, 1'b0);
`ifndef ADO_REFRACTORY_EN
        chk("sat_detect", bus.spike_valid, 1);
`endif
        override_en = 1'b1;
        thr_override = 16'sd32766;
        for (int i = 0; i < 3; i++) cyc(1'b1, -32768, 1'b0);
`ifndef ADO_REFRACTORY_EN
        chk("sat_gt_32766", bus.spike_valid, 1);
`endif
        thr_override = 16'sd32767;
        cyc(1'b1, -32768, 1'b0); cyc(1'b1, -32768, 1'b0);
        cyc(1'b1, 32767, 1'b0);
        chk("ovr_thr_max", threshold_out, 32767);
`ifndef ADO_REFRACTORY_EN
        chk("sat_eq_32767", bus.spike_valid, 0);
`endif

        // Negative override: every qualified sample detects; detect+accept re-arms
        thr_override = -16'sd5;
        cyc(1'b0, 0, 1'b0);
        chk("ovr_neg_thr", threshold_out, -5);
        cnt0 = m_count;
        for (int i = 0; i < 5; i++) cyc(1'b1, 7, 1'b0);
`ifndef ADO_REFRACTORY_EN
        chk("neg_valid", bus.spike_valid, 1);
        chk("neg_count", event_count, (cnt0 + 4) % 65536);
`endif
        override_en = 1'b0;
        cyc(1'b0, 0, 1'b0);
        chk("ovr_restore", threshold_out, 800);

        // start beats a same-cycle detection and keeps the pending event
        for (int i = 0; i < 20 && m_state != 2; i++) cyc(1'b1, 7, 1'b0);
        override_en = 1'b1;
        thr_override = -16'sd5;
        cyc(1'b0, 0, 1'b0);
        bus.spike_ready = 1'b0;
        cyc(1'b1, 7, 1'b0);
        cyc(1'b1, 7, 1'b0);
`ifndef ADO_REFRACTORY_EN
        chk("pre_start_drop", spike_drop, 1);
`endif
        cnt0 = m_count;
        cyc(1'b1, 7, 1'b1);
        chk("start_state", state_out, 1);
        chk("start_drop", spike_drop, 0);
        chk("start_valid", bus.spike_valid, 1);
        chk("start_count", event_count, cnt0);
        override_en = 1'b0;

        // Reset mid-training abandons it
        for (int i = 0; i < 100; i++) begin
            bus.spike_ready = 1'($urandom);
            cyc(1'b1, rnd16(), 1'b0);
        end
        do_reset();
        chk("rst_mid_state", state_out, 0);
        chk("rst_mid_thr", threshold_out, 500);
        chk("rst_mid_valid", bus.spike_valid, 0);
        chk("rst_mid_count", event_count, 0);

        // Random full-range training (saturating threshold) and operation
        cyc(1'b0, 0, 1'b1);
        for (int i = 0; i < 3000 && m_state != 2; i++)
            cyc($urandom_range(0, 3) != 0, rnd16(), 1'b0);
        chk("rand_train_done", state_out, 2);
        for (int i = 0; i < 400; i++) begin
            bus.spike_ready = 1'($urandom);
            if ($urandom_range(0, 49) == 0) override_en = ~override_en;
            if ($urandom_range(0, 19) == 0) thr_override = 16'(rnd16());
            cyc($urandom_range(0, 3) != 0, rnd16(), $urandom_range(0, 299) == 0);
        end

        // Random small-amplitude training and operation
        override_en = 1'b0;
        cyc(1'b0, 0, 1'b1);
        for (int i = 0; i < 3000 && m_state != 2; i++)
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 300)), 1'b0);
        chk("small_train_done", state_out, 2);
        for (int i = 0; i < 300; i++) begin
            bus.spike_ready = 1'($urandom);
            cyc($urandom_range(0, 3) != 0, int'($urandom_range(0, 2000)), 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
